// File: rtl/flash_playback_controller.sv
// Flash audio playback sequencer: owns the play/pause state, direction, flash word
// address and the sample-rate tick that paces read requests to the flash reader.
module flash_playback_controller #(
  parameter int unsigned       ADDR_W      = 23,
  parameter logic [ADDR_W-1:0] START_ADDR  = 23'd0,
  parameter logic [ADDR_W-1:0] END_ADDR    = 23'h7FFFF,
  parameter logic [15:0]       DIV_DEFAULT = 16'd1136,
  parameter logic [15:0]       DIV_STEP    = 16'd32,
  parameter logic [15:0]       DIV_MIN     = 16'd256,
  parameter logic [15:0]       DIV_MAX     = 16'd4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kbd_valid,
  input  logic [2:0]        kbd_cmd,
  input  logic              address_change,
  output logic              pause,
  output logic              startsamplenow,
  output logic [ADDR_W-1:0] flsh_address,
  output logic              direction,
  output logic [15:0]       divisor,
  output logic              overrun
);

  typedef enum logic [0:0] {
    ST_PLAYING = 1'b0,
    ST_PAUSED  = 1'b1
  } state_e;

  localparam logic [2:0] CMD_PLAY    = 3'd0;
  localparam logic [2:0] CMD_PAUSE   = 3'd1;
  localparam logic [2:0] CMD_FWD     = 3'd2;
  localparam logic [2:0] CMD_BWD     = 3'd3;
  localparam logic [2:0] CMD_RESTART = 3'd4;
  localparam logic [2:0] CMD_FASTER  = 3'd5;
  localparam logic [2:0] CMD_SLOWER  = 3'd6;
  localparam logic [2:0] CMD_SPDRST  = 3'd7;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              pause_q, pause_d;
  logic              start_q, start_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dir_q, dir_d;
  logic [15:0]       div_q, div_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              outst_q, outst_d;
  logic              ovr_q, ovr_d;

  logic              restart_s;
  logic              pause_cmd_s;
  logic              tick_s;
  logic              outst_left_s;
  logic [ADDR_W-1:0] addr_step_s;
  logic [16:0]       div_up_s;
  logic [15:0]       div_faster_s;
  logic [15:0]       div_slower_s;

  // Command decode, tick detection, wrapped address step and saturated divisor values.
  always_comb begin
    restart_s    = kbd_valid && (kbd_cmd == CMD_RESTART);
    pause_cmd_s  = kbd_valid && (kbd_cmd == CMD_PAUSE);
    tick_s       = (state_q == ST_PLAYING) && !pause_cmd_s && !restart_s &&
                   (cnt_q >= (div_q - 16'd1));
    // an acknowledge in the same cycle frees the slot before the tick looks at it
    outst_left_s = outst_q && !address_change;
    div_up_s     = {1'b0, div_q} + {1'b0, DIV_STEP};
    if (div_up_s > {1'b0, DIV_MAX}) begin
      div_slower_s = DIV_MAX;
    end else begin
      div_slower_s = div_up_s[15:0];
    end
    if ({1'b0, div_q} >= ({1'b0, DIV_MIN} + {1'b0, DIV_STEP})) begin
      div_faster_s = div_q - DIV_STEP;
    end else begin
      div_faster_s = DIV_MIN;
    end
    if (dir_q) begin
      if (addr_q == START_ADDR) begin
        addr_step_s = END_ADDR;
      end else begin
        addr_step_s = addr_q - ADDR_ONE;
      end
    end else begin
      if (addr_q == END_ADDR) begin
        addr_step_s = START_ADDR;
      end else begin
        addr_step_s = addr_q + ADDR_ONE;
      end
    end
  end

  // Next-state logic for the play/pause FSM, address, divisor and sample handshake.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    div_d   = div_q;
    if (kbd_valid) begin
      case (kbd_cmd)
        CMD_PLAY:   state_d = ST_PLAYING;
        CMD_PAUSE:  state_d = ST_PAUSED;
        CMD_FWD:    dir_d   = 1'b0;
        CMD_BWD:    dir_d   = 1'b1;
        CMD_FASTER: div_d   = div_faster_s;
        CMD_SLOWER: div_d   = div_slower_s;
        CMD_SPDRST: div_d   = DIV_DEFAULT;
        default: begin
          state_d = state_q;
          dir_d   = dir_q;
          div_d   = div_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    pause_d = (state_d == ST_PAUSED);

    if (restart_s || tick_s || (state_d == ST_PAUSED) || (state_q == ST_PAUSED)) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    if (restart_s) begin
      outst_d = 1'b0;
      ovr_d   = 1'b0;
      start_d = 1'b0;
    end else if (tick_s) begin
      outst_d = 1'b1;
      ovr_d   = ovr_q | outst_left_s;
      start_d = !outst_left_s;
    end else begin
      outst_d = outst_left_s;
      ovr_d   = ovr_q;
      start_d = 1'b0;
    end

    // restart outranks a concurrent acknowledge; the step uses the pre-command direction
    if (restart_s) begin
      if (dir_q) begin
        addr_d = END_ADDR;
      end else begin
        addr_d = START_ADDR;
      end
    end else if (address_change) begin
      addr_d = addr_step_s;
    end else begin
      addr_d = addr_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_PLAYING;
      pause_q <= 1'b0;
      start_q <= 1'b0;
      addr_q  <= START_ADDR;
      dir_q   <= 1'b0;
      div_q   <= DIV_DEFAULT;
      cnt_q   <= 16'd0;
      outst_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pause_q <= pause_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      dir_q   <= dir_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      outst_q <= outst_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pause          = pause_q;
  assign startsamplenow = start_q;
  assign flsh_address   = addr_q;
  assign direction      = dir_q;
  assign divisor        = div_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_flash_playback_controller.sv
// Self-checking bench for flash_playback_controller: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural reference model.
module tb_flash_playback_controller;

  localparam int P_START = 0;
  localparam int P_END   = 3;
  localparam int P_N     = P_END - P_START + 1;
  localparam int P_DEF   = 8;
  localparam int P_STEP  = 2;
  localparam int P_MIN   = 4;
  localparam int P_MAX   = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        kbd_valid = 1'b0;
  logic [2:0]  kbd_cmd = 3'd0;
  logic        address_change = 1'b0;
  logic        pause;
  logic        startsamplenow;
  logic [22:0] flsh_address;
  logic        direction;
  logic [15:0] divisor;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_playing, m_dir, m_waiting, m_ovr, m_start;
  int m_addr, m_div, m_elapsed;

  flash_playback_controller #(
    .ADDR_W(23), .START_ADDR(23'd0), .END_ADDR(23'd3),
    .DIV_DEFAULT(16'd8), .DIV_STEP(16'd2), .DIV_MIN(16'd4), .DIV_MAX(16'd12)
  ) dut (
    .clk(clk), .reset(reset), .kbd_valid(kbd_valid), .kbd_cmd(kbd_cmd),
    .address_change(address_change), .pause(pause), .startsamplenow(startsamplenow),
    .flsh_address(flsh_address), .direction(direction), .divisor(divisor), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit rst, input bit v, input int cmd, input bit ac);
    bit restart, tick, next_playing, old_dir;
    if (rst) begin
      m_playing = 1; m_dir = 0; m_waiting = 0; m_ovr = 0; m_start = 0;
      m_addr = P_START; m_div = P_DEF; m_elapsed = 0;
      return;
    end
    restart = v && cmd == 4;
    old_dir = m_dir;
    tick = m_playing && !(v && cmd == 1) && !restart && (m_elapsed + 1 >= m_div);
    next_playing = m_playing;
    if (v) begin
      case (cmd)
        0: next_playing = 1;
        1: next_playing = 0;
        2: m_dir = 0;
        3: m_dir = 1;
        5: m_div = (m_div - P_STEP < P_MIN) ? P_MIN : m_div - P_STEP;
        6: m_div = (m_div + P_STEP > P_MAX) ? P_MAX : m_div + P_STEP;
        7: m_div = P_DEF;
        default: ;
      endcase
    end
    m_start = 0;
    if (restart) begin
      m_waiting = 0; m_ovr = 0;
      m_addr = old_dir ? P_END : P_START;
    end else begin
      if (ac) begin
        m_waiting = 0;
        m_addr = P_START + ((m_addr - P_START + (old_dir ? P_N - 1 : 1)) % P_N);
      end
      if (tick) begin
        if (m_waiting) m_ovr = 1;
        else begin m_start = 1; m_waiting = 1; end
      end
    end
    m_elapsed = (restart || tick || !next_playing || !m_playing) ? 0 : m_elapsed + 1;
    m_playing = next_playing;
  endtask

  // one clock: model consumes the applied inputs, DUT samples them, pulses then drop
  task automatic clk_step();
    model_step(reset, kbd_valid, int'(kbd_cmd), address_change);
    @(posedge clk);
    #1;
    kbd_valid = 1'b0;
    address_change = 1'b0;
  endtask

  task automatic send_cmd(input int cmd);
    kbd_valid = 1'b1;
    kbd_cmd = 3'(cmd);
    clk_step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clk_step();
    clk_step();
    checks++; if (pause !== 1'b0) begin errors++; $display("FAIL reset_pause: got %0b expected 0", pause); end
    checks++; if (startsamplenow !== 1'b0) begin errors++; $display("FAIL reset_start: got %0b expected 0", startsamplenow); end
    checks++; if (flsh_address !== 23'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", flsh_address); end
    checks++; if (direction !== 1'b0) begin errors++; $display("FAIL reset_dir: got %0b expected 0", direction); end
    checks++; if (divisor !== 16'd8) begin errors++; $display("FAIL reset_div: got %0d expected 8", divisor); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %0b expected 0", overrun); end
  endtask

  task automatic test_play();
    int exp_seq[5] = '{1, 2, 3, 0, 1};
    int consumed = 0;
    int n;
    reset = 1'b0;
    for (int p = 0; p < 5; p++) begin
      n = 0;
      while (startsamplenow !== 1'b1 && n < 40) begin clk_step(); n++; end
      checks++; if (n + consumed != 8) begin errors++; $display("FAIL play_gap: got %0d expected 8", n + consumed); end
      clk_step();
      checks++; if (startsamplenow !== 1'b0) begin errors++; $display("FAIL play_pulse_width: got %0b expected 0", startsamplenow); end
      clk_step();
      address_change = 1'b1;
      clk_step();
      checks++; if (flsh_address !== 23'(exp_seq[p])) begin errors++; $display("FAIL play_addr: got %0d expected %0d", flsh_address, exp_seq[p]); end
      consumed = 3;
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL play_ovr: got %0b expected 0", overrun); end
  endtask

  task automatic test_backward();
    send_cmd(4);
    checks++; if (flsh_address !== 23'd0) begin errors++; $display("FAIL bwd_restart_addr: got %0d expected 0", flsh_address); end
    send_cmd(3);
    checks++; if (direction !== 1'b1) begin errors++; $display("FAIL bwd_dir: got %0b expected 1", direction); end
    address_change = 1'b1; clk_step();
    checks++; if (flsh_address !== 23'd3) begin errors++; $display("FAIL bwd_wrap: got %0d expected 3", flsh_address); end
    address_change = 1'b1; clk_step();
    checks++; if (flsh_address !== 23'd2) begin errors++; $display("FAIL bwd_step: got %0d expected 2", flsh_address); end
    // forward command together with an acknowledge: step still goes backward
    address_change = 1'b1; send_cmd(2);
    checks++; if (flsh_address !== 23'd1 || direction !== 1'b0) begin errors++; $display("FAIL dir_collision: got addr %0d dir %0b expected addr 1 dir 0", flsh_address, direction); end
    address_change = 1'b1; clk_step();
    checks++; if (flsh_address !== 23'd2) begin errors++; $display("FAIL fwd_step: got %0d expected 2", flsh_address); end
    send_cmd(4);
  endtask

  task automatic test_pause_play();
    int pulses = 0;
    int n = 0;
    send_cmd(1);
    checks++; if (pause !== 1'b1) begin errors++; $display("FAIL pause_state: got %0b expected 1", pause); end
    for (int i = 0; i < 50; i++) begin
      clk_step();
      if (startsamplenow === 1'b1) pulses++;
    end
    checks++; if (pulses != 0 || pause !== 1'b1) begin errors++; $display("FAIL pause_quiet: got %0d pulses pause %0b expected 0 pulses pause 1", pulses, pause); end
    send_cmd(0);
    checks++; if (pause !== 1'b0) begin errors++; $display("FAIL play_state: got %0b expected 0", pause); end
    while (startsamplenow !== 1'b1 && n < 40) begin clk_step(); n++; end
    checks++; if (n != 8) begin errors++; $display("FAIL play_first_pulse: got %0d expected 8", n); end
    address_change = 1'b1; clk_step();
  endtask

  task automatic test_speed();
    int cmds[9] = '{5, 5, 5, 6, 6, 6, 6, 6, 7};
    int exps[9] = '{6, 4, 4, 6, 8, 10, 12, 12, 8};
    for (int i = 0; i < 9; i++) begin
      send_cmd(cmds[i]);
      checks++; if (divisor !== 16'(exps[i])) begin errors++; $display("FAIL speed_div[%0d]: got %0d expected %0d", i, divisor, exps[i]); end
    end
  endtask

  task automatic test_overrun();
    int pulses = 0;
    send_cmd(4);
    for (int i = 0; i < 20; i++) begin
      clk_step();
      if (startsamplenow === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", pulses); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %0b expected 1", overrun); end
    send_cmd(4);
    checks++; if (overrun !== 1'b0 || flsh_address !== 23'd0) begin errors++; $display("FAIL ovr_restart: got ovr %0b addr %0d expected ovr 0 addr 0", overrun, flsh_address); end
  endtask

  task automatic test_collision_reset();
    int n = 0;
    address_change = 1'b1; clk_step();
    address_change = 1'b1; clk_step();
    checks++; if (flsh_address !== 23'd2) begin errors++; $display("FAIL coll_setup: got %0d expected 2", flsh_address); end
    address_change = 1'b1; send_cmd(4);
    checks++; if (flsh_address !== 23'd0) begin errors++; $display("FAIL coll_restart: got %0d expected 0", flsh_address); end
    send_cmd(3);
    send_cmd(5);
    clk_step(); clk_step(); clk_step();
    reset = 1'b1; address_change = 1'b1; send_cmd(1);
    checks++; if (pause !== 1'b0 || startsamplenow !== 1'b0 || flsh_address !== 23'd0 ||
                  direction !== 1'b0 || divisor !== 16'd8 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: got pause %0b start %0b addr %0d dir %0b div %0d ovr %0b expected 0 0 0 0 8 0",
               pause, startsamplenow, flsh_address, direction, divisor, overrun);
    end
    reset = 1'b0;
    while (startsamplenow !== 1'b1 && n < 40) begin clk_step(); n++; end
    checks++; if (n != 8) begin errors++; $display("FAIL midrun_first_pulse: got %0d expected 8", n); end
  endtask

  task automatic test_random();
    int c;
    reset = 1'b1; clk_step(); reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      address_change = ($urandom_range(0, 5) == 0);
      kbd_valid = ($urandom_range(0, 9) == 0);
      c = $urandom_range(0, 6);
      if (c >= 4) c++;
      kbd_cmd = 3'(c);
      clk_step();
      checks++; if (pause !== !m_playing) begin errors++; $display("FAIL rnd_pause @%0d: got %0b expected %0b", i, pause, !m_playing); end
      checks++; if (startsamplenow !== m_start) begin errors++; $display("FAIL rnd_start @%0d: got %0b expected %0b", i, startsamplenow, m_start); end
      checks++; if (flsh_address !== 23'(m_addr)) begin errors++; $display("FAIL rnd_addr @%0d: got %0d expected %0d", i, flsh_address, m_addr); end
      checks++; if (direction !== m_dir) begin errors++; $display("FAIL rnd_dir @%0d: got %0b expected %0b", i, direction, m_dir); end
      checks++; if (divisor !== 16'(m_div)) begin errors++; $display("FAIL rnd_div @%0d: got %0d expected %0d", i, divisor, m_div); end
      checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rnd_ovr @%0d: got %0b expected %0b", i, overrun, m_ovr); end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_play();
    test_backward();
    test_pause_play();
    test_speed();
    test_overrun();
    test_collision_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_playback_controller.md
# flash_playback_controller

Sequencer for the flash audio playback path. It owns the flash word address, the play/pause state, the playback direction and the sample-rate tick. It turns one-cycle keyboard command pulses into the `pause` and `startsamplenow` controls consumed by the flash reader. It advances or rewinds the address each time the reader reports `address_change`.

## Interface
Parameters:
- `ADDR_W`, 23: flash word-address width.
- `START_ADDR`, 0: first word of the audio region.
- `END_ADDR`, 23'h7FFFF: last word of the audio region; must be greater than `START_ADDR`.
- `DIV_DEFAULT`, 1136: clocks per sample after reset or speed-reset (50 MHz / 44 kHz).
- `DIV_STEP`, 32: divisor change per faster/slower command.
- `DIV_MIN`, 256: lower saturation bound for the divisor.
- `DIV_MAX`, 4095: upper saturation bound for the divisor.

Ports:
- `clk` in 1: the single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `kbd_valid` in 1: one-cycle pulse marking a valid `kbd_cmd`.
- `kbd_cmd` in 3: command code; 0 play, 1 pause, 2 forward, 3 backward, 4 restart, 5 faster, 6 slower, 7 speed-reset.
- `address_change` in 1: one-cycle pulse from the reader when the current word has been consumed.
- `pause` out 1: 1 while the controller is in the PAUSED state.
- `startsamplenow` out 1: one-cycle sample request to the reader.
- `flsh_address` out ADDR_W: current flash word address.
- `direction` out 1: 0 = forward, 1 = backward.
- `divisor` out 16: current clocks-per-sample value.
- `overrun` out 1: sticky flag; a tick arrived while a sample was still outstanding.

## Operation
- The state machine has two states, PLAYING and PAUSED.
- Reset values:
  - state PLAYING, so `pause`=0;
  - `direction`=0, `flsh_address`=`START_ADDR`;
  - `divisor`=`DIV_DEFAULT`;
  - `startsamplenow`=0, `overrun`=0;
  - tick counter=0, outstanding=0.
- Commands are acted on only when `kbd_valid`=1. Codes 0 and 1 set the state. Codes 2 and 3 set `direction`.
- Restart (4):
  - `flsh_address` goes to `START_ADDR` if forward, `END_ADDR` if backward;
  - the tick counter, outstanding and `overrun` are cleared;
  - the play/pause state is unchanged.
- Faster (5): divisor = max(divisor − `DIV_STEP`, `DIV_MIN`).
- Slower (6): divisor = min(divisor + `DIV_STEP`, `DIV_MAX`).
- Speed-reset (7): divisor = `DIV_DEFAULT`.
- Tick counter:
  - in PLAYING it increments every clock;
  - when counter ≥ divisor−1, a tick fires and the counter returns to 0;
  - the ≥ compare means a divisor lowered below the current count fires on the next clock;
  - in PAUSED the counter is held at 0.
- On a tick with outstanding=0: pulse `startsamplenow` and set outstanding=1.
- On a tick with outstanding=1: no pulse; `overrun` is set to 1.
- On `address_change`:
  - clear outstanding;
  - forward: address = (addr==`END_ADDR`) ? `START_ADDR` : addr+1;
  - backward: address = (addr==`START_ADDR`) ? `END_ADDR` : addr−1;
  - `address_change` is honoured in PAUSED as well, so an in-flight read completes.
- Simultaneous events:
  - restart together with `address_change`: restart wins and the address takes the restart value;
  - direction change together with `address_change`: the step uses the old direction;
  - tick together with `address_change` while outstanding=1: outstanding is cleared first, so a pulse is issued and no overrun is flagged;
  - pause command together with a tick: the tick is suppressed.
- Reset asserted mid-operation restores all reset values on the next edge, regardless of any other input.

## Timing
- All outputs are registered.
- Command latency: a command sampled at edge n appears on the outputs after edge n.
- From play (or reset release), the first `startsamplenow` rises after `divisor` clocks. Subsequent pulses are exactly `divisor` clocks apart while the reader keeps up.
- `startsamplenow` is high for exactly one cycle.
- `flsh_address` updates on the edge that samples `address_change`. It is stable from then until the next `address_change`, restart or reset.
- `divisor` arithmetic is 16-bit unsigned with saturation; it never leaves [`DIV_MIN`, `DIV_MAX`] except for `DIV_DEFAULT`.

## Test plan
Bench parameters: `DIV_DEFAULT`=8, `DIV_STEP`=2, `DIV_MIN`=4, `DIV_MAX`=12, `START_ADDR`=0, `END_ADDR`=3.
- **Reset and play:** release reset, answer each `startsamplenow` with `address_change` 3 cycles later → pulses every 8 cycles, address sequence 1,2,3,0,1, `overrun` stays 0.
- **Backward wrap:** backward command at address 0, then one `address_change` → `direction`=1, address 3, then 2.
- **Pause and play:** pause command → no `startsamplenow` for 50 cycles, `pause`=1; play command → first pulse 8 cycles later.
- **Speed saturation:** faster ×3 → `divisor` 6, 4, 4; slower ×5 → `divisor` 6, 8, 10, 12, 12; speed-reset → 8.
- **Overrun:** withhold `address_change` for 20 cycles → exactly one `startsamplenow`, then `overrun`=1; restart → `overrun`=0, address 0.
- **Restart collision and mid-run reset:** restart in the same cycle as `address_change` at address 2 → address 0. Reset mid-count → all outputs return to reset values on the next edge.
